// File: rtl/prism_aux_pkg.sv
// Shared constants for the PRISM auxiliary counter/shift block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package prism_aux_pkg;

   // Register map within the peripheral space
   localparam logic [5:0] ADDR_SHIFT     = 6'h18;
   localparam logic [5:0] ADDR_STATUS    = 6'h1C;
   localparam logic [5:0] ADDR_CHAN_BASE = 6'h20;

   // Field positions inside the 32-bit registers
   localparam int AUTO_BIT = 31;
   localparam int IE_BIT   = 30;
   localparam int PEND_BIT = 29;
   localparam int DIR_BIT  = 16;
   localparam int SEL_LSB  = 24;

   // Only full-word writes are honoured
   localparam logic [1:0] WR32 = 2'b10;

endpackage

// File: rtl/prism_aux_counters_if.sv
// TinyQV data-bus slice seen by the auxiliary counter block.
// Latency: read data is combinational, writes land on the next clk edge.
// Backpressure: none; every access completes in one cycle.
interface prism_aux_counters_if;

   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [31:0] data_out;

   modport master (output address, output data_in, output data_write_n, input data_out);
   modport slave  (input address, input data_in, input data_write_n, output data_out);

endinterface

// File: rtl/prism_aux_chan.sv
// One countdown channel: count, preload, auto-reload, interrupt enable, pending.
// Latency: strobes and writes take effect at the next clk edge.
// Backpressure: none; strobes are always accepted (halt freezes the count).
module prism_aux_chan
   import prism_aux_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_preload,
   input  logic             wr_auto,
   input  logic             wr_ie,
   input  logic             clr,
   input  logic             fsm_enable,
   input  logic             fsm_halt,
   input  logic             dec,
   input  logic             load,
   output logic [31:0]      rd_dat,
   output logic             zero,
   output logic             pending,
   output logic             ie
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] preload;
   logic             auto_rl;
   logic             pend_set;

   // Next count and pending-set, highest priority first; halt freezes everything
   always_comb begin
      count_nxt = count;
      pend_set  = 1'b0;
      if (!fsm_halt) begin
         if (load && dec) begin
            count_nxt = count;
         end else if (load && fsm_enable) begin
            count_nxt = preload;
         end else if (dec) begin
            if (count != '0) begin
               count_nxt = count - CNT_W'(1);
               pend_set  = (count == CNT_W'(1));
            end else if (auto_rl) begin
               count_nxt = preload;
            end
         end
      end
   end

   // Channel state; bus writes only touch configuration, never the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         preload <= '0;
         auto_rl <= 1'b0;
         ie      <= 1'b0;
         pending <= 1'b0;
      end else begin
         count <= count_nxt;
         if (wr_en) begin
            preload <= wr_preload;
            auto_rl <= wr_auto;
            ie      <= wr_ie;
         end
         // a new event outranks a same-cycle clear so no interrupt is lost
         if (pend_set)
            pending <= 1'b1;
         else if (clr)
            pending <= 1'b0;
      end
   end

   // Readback image of the CHAN register
   always_comb begin
      rd_dat             = '0;
      rd_dat[CNT_W-1:0]  = count;
      rd_dat[AUTO_BIT]   = auto_rl;
      rd_dat[IE_BIT]     = ie;
      rd_dat[PEND_BIT]   = pending;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/prism_aux_counters.sv
// PRISM auxiliary block: NUM_CNT countdown channels plus a bidirectional comm shifter.
// Latency: writes/strobes land on the next clk edge; reads and flags are combinational from state.
// Backpressure: none; bus accesses and strobes complete every cycle.
module prism_aux_counters
   import prism_aux_pkg::*;
#(
   parameter int NUM_CNT = 2,
   parameter int CNT_W   = 24,
   parameter int SHIFT_W = 8,
   parameter int SEL_W   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prism_aux_counters_if.slave   bus,
   input  logic                  fsm_enable,
   input  logic                  fsm_halt,
   input  logic [NUM_CNT-1:0]    cnt_dec,
   input  logic [NUM_CNT-1:0]    cnt_load,
   input  logic                  shift_en,
   input  logic [2**SEL_W-1:0]   comm_in,
   output logic [NUM_CNT-1:0]    cnt_zero,
   output logic                  shift_out,
   output logic                  irq
);

   logic               wr32;
   logic               chan_hit;
   logic [2:0]         chan_idx;
   logic               shift_wr;
   logic               status_wr;
   logic [SHIFT_W-1:0] sh_dat;
   logic               sh_dir;
   logic [SEL_W-1:0]   sh_sel;
   logic               comm_bit;
   logic [NUM_CNT-1:0] pend_vec;
   logic [NUM_CNT-1:0] ie_vec;
   logic [31:0]        chan_rd [NUM_CNT];
   logic [31:0]        rd_mux;
   logic               unused_wdat;

   // Channel window is 0x20..0x3C, word aligned
   assign wr32      = (bus.data_write_n == WR32);
   assign chan_hit  = (bus.address[5] == ADDR_CHAN_BASE[5]) && (bus.address[1:0] == 2'b00);
   assign chan_idx  = bus.address[4:2];
   assign shift_wr  = wr32 && (bus.address == ADDR_SHIFT);
   assign status_wr = wr32 && (bus.address == ADDR_STATUS);
   assign comm_bit  = comm_in[sh_sel];

   // Not every write-data bit maps to a register field
   assign unused_wdat = ^bus.data_in;

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_chan
      prism_aux_chan #(.CNT_W(CNT_W)) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_en      (wr32 && chan_hit && (chan_idx == 3'(g))),
         .wr_preload (bus.data_in[CNT_W-1:0]),
         .wr_auto    (bus.data_in[AUTO_BIT]),
         .wr_ie      (bus.data_in[IE_BIT]),
         .clr        (status_wr && bus.data_in[g]),
         .fsm_enable (fsm_enable),
         .fsm_halt   (fsm_halt),
         .dec        (cnt_dec[g]),
         .load       (cnt_load[g]),
         .rd_dat     (chan_rd[g]),
         .zero       (cnt_zero[g]),
         .pending    (pend_vec[g]),
         .ie         (ie_vec[g])
      );
   end

   // Comm shifter; a bus write in the same cycle replaces the shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_dat <= '0;
         sh_dir <= 1'b0;
         sh_sel <= '0;
      end else if (shift_wr) begin
         sh_dat <= bus.data_in[SHIFT_W-1:0];
         sh_dir <= bus.data_in[DIR_BIT];
         sh_sel <= bus.data_in[SEL_LSB +: SEL_W];
      end else if (shift_en && !fsm_halt) begin
         sh_dat <= sh_dir ? {comm_bit, sh_dat[SHIFT_W-1:1]}
                          : {sh_dat[SHIFT_W-2:0], comm_bit};
      end
   end

   // Bit about to leave the register in the current direction
   assign shift_out = sh_dir ? sh_dat[0] : sh_dat[SHIFT_W-1];
   assign irq       = |(pend_vec & ie_vec);

   // Combinational read mux; unmapped addresses and unused bits read 0
   always_comb begin
      rd_mux = '0;
      if (bus.address == ADDR_SHIFT) begin
         rd_mux[SHIFT_W-1:0]        = sh_dat;
         rd_mux[DIR_BIT]            = sh_dir;
         rd_mux[SEL_LSB +: SEL_W]   = sh_sel;
      end else if (bus.address == ADDR_STATUS) begin
         rd_mux[NUM_CNT-1:0] = pend_vec;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (chan_hit && (chan_idx == 3'(i)))
               rd_mux = chan_rd[i];
         end
      end
   end

   assign bus.data_out = rd_mux;

endmodule

// File: doc/prism_aux_counters.md
# prism_aux_counters

Parametrised auxiliary counter and shift block for the next-generation PRISM peripheral. It replaces the fixed 24-bit countdown, 4-bit up-counter and 8-bit comm shifter with the following:
- NUM_CNT independent countdown channels, each with one-shot or auto-reload mode and per-channel interrupt.
- A SHIFT_W-bit bidirectional comm shift register with selectable input.

It sits between the TinyQV data bus and the PRISM FSM. PRISM outputs drive its strobes, and its flags feed PRISM inputs.

## Interface
Parameters:
- NUM_CNT, 2, number of countdown channels (1..8)
- CNT_W, 24, counter/preload width (1..24)
- SHIFT_W, 8, comm shift register width (2..16)
- SEL_W, 2, comm input select width; the block has 2**SEL_W comm inputs

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  reset; asynchronous, active-low
- address  in  6  register address within peripheral space
- data_in  in  32  write data
- data_write_n  in  2  only 2'b10 (32-bit) writes are accepted; other codes are ignored
- data_out  out  32  combinational read data
- fsm_enable  in  1  PRISM enable; gates loads
- fsm_halt  in  1  PRISM halted; freezes all strobe-driven updates
- cnt_dec  in  NUM_CNT  per-channel decrement strobe
- cnt_load  in  NUM_CNT  per-channel load-from-preload strobe
- shift_en  in  1  comm shift strobe
- comm_in  in  2**SEL_W  candidate serial inputs
- cnt_zero  out  NUM_CNT  count==0 per channel
- shift_out  out  1  serial-out bit: MSB when shifting left, LSB when shifting right
- irq  out  1  OR of (pending & ie)

## Operation
- Registers are read combinationally. Unmapped addresses read 0.
- 0x18 SHIFT register:
  - Fields: [SHIFT_W-1:0] data, [16] dir (0 = left, new bit enters at LSB; 1 = right, new bit enters at MSB), [24+SEL_W-1:24] sel.
- 0x1C STATUS register:
  - Read: [NUM_CNT-1:0] pending.
  - Write: 1 in bit i clears pending[i] (write-1-to-clear).
- 0x20+4*i CHAN_i register:
  - Write: sets preload[CNT_W-1:0], auto[31], ie[30]. Count is unchanged.
  - Read: count in [CNT_W-1:0], auto[31], ie[30], pending[29].
- Channel i next-state, in priority order:
  1. Halted (fsm_halt=1): hold.
  2. cnt_load & cnt_dec both set: hold.
  3. cnt_load & fsm_enable: count <= preload.
  4. cnt_dec with count≠0: count <= count−1. If count==1, also set pending[i].
  5. cnt_dec with count==0: auto=1 gives count <= preload; auto=0 holds 0.
- CHAN_i bus writes never touch count, so they never conflict with strobes.
- Pending: a set and a W1C clear in the same cycle resolve to set. Decrement from 0 or reload never sets pending.
- Shift: shift_en & !fsm_halt shifts by one using comm_in[sel]. A bus write to SHIFT in the same cycle wins and the shift is lost.
- cnt_zero = (count==0), combinational from the count register.

## Timing
- Writes take effect at the next clk edge. Read data reflects register state in the same cycle.
- Strobes are sampled at clk edge. cnt_zero, shift_out and irq update one cycle after the causing strobe/write.
- Counter wrap: there is no underflow; count saturates at 0 (one-shot) or reloads (auto).
- Reset (asynchronous, any time, including mid-count or mid-shift) values:
  - count, preload, auto, ie, pending, shift data, dir and sel are 0.
  - Outputs: cnt_zero all 1s, shift_out=0, irq=0, data_out reflects zeros.

## Structure
- Package prism_aux_pkg holds:
  - Address constants ADDR_SHIFT=6'h18, ADDR_STATUS=6'h1C, ADDR_CHAN_BASE=6'h20.
  - Bit positions: AUTO_BIT=31, IE_BIT=30, PEND_BIT=29, DIR_BIT=16, SEL_LSB=24.
  - Write-size code WR32=2'b10.
- Sub-module prism_aux_chan:
  - Contains one channel's count, preload, auto, ie and pending logic.
  - Instantiated NUM_CNT times by generate.
- The top level holds address decode, the shift register, the read mux and the irq reduction.

## Test plan
- Channel preload and count-down:
  - Stimulus: write CHAN0=0x0000_0003 with ie=0, pulse cnt_load with fsm_enable=1, then 3 cnt_dec pulses.
  - Required response: count 3→2→1→0; cnt_zero[0] rises on the cycle after the third pulse; pending[0]=1; irq=0.
- Auto-reload with interrupt:
  - Stimulus: set auto=1, ie=1, preload=2; load, then dec×3.
  - Required response: count 2,1,0,2; irq=1 after the count reaches 0.
  - Then write STATUS=0x1: irq=0 next cycle.
- Simultaneous events:
  - dec and load together hold the count.
  - fsm_halt=1 with dec pulses holds the count.
  - Pending-set coinciding with a W1C clear leaves pending=1.
- Comm shift:
  - Stimulus: write SHIFT with data=0x81, dir=0, sel=2; comm_in[2]=1; shift_en×2.
  - Required response: data 0x03 then 0x07; shift_out=1, 0, 0.
  - Repeat with dir=1: data 0xC0, then 0xE0.
- Write priority:
  - A SHIFT write coinciding with shift_en loads the written value exactly.
  - A CHAN write during counting changes preload only.
- Asynchronous reset:
  - Stimulus: assert rst_n low mid-count between clock edges.
  - Required response: all counts 0, cnt_zero all 1s, irq=0 immediately, without waiting for a clock edge.
- Parameter sweep:
  - Configurations: NUM_CNT=8, CNT_W=16, SHIFT_W=16.
  - Required response: address 0x3C maps to CHAN7; unused high bits read 0.
